// File: rtl/core_seq_pkg.sv
// Shared types and opcode constants for the RV32I multi-cycle sequencer.
// Also holds the data-access alignment rule used by both EXEC and the LSU.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } seqstate_t;

  // Instruction format reported by the decoder; IT_ILL marks anything it rejects.
  typedef enum logic [2:0] {
    IT_R,
    IT_I,
    IT_S,
    IT_B,
    IT_U,
    IT_J,
    IT_ILL
  } instype_t;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_LINK
  } wbsel_t;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OP_OP     = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

  localparam logic [31:0] INS_NOP = 32'h0000_0013;

  // funct3[1:0] encodes access size: 00 byte, 01 half, 1x word.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    case (funct3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/core_seq_lsu_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Low address bits below the access size are ignored here.
module core_seq_lsu_align
  import core_seq_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);
  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    case (funct3[1:0])
      2'b00:   off = addr_lo;
      2'b01:   off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  assign shifted = ld_word >> {off, 3'b000};

  always_comb begin
    be      = 4'b1111;
    wdata   = st_data;
    ld_data = ld_word;
    case (funct3[1:0])
      2'b00: begin
        be      = 4'b0001 << off;
        wdata   = {4{st_data[7:0]}};
        ld_data = funct3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        be      = 4'b0011 << off;
        wdata   = {2{st_data[15:0]}};
        ld_data = funct3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be      = 4'b1111;
        wdata   = st_data;
        ld_data = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: FETCH -> EXEC -> (MEM) -> WB, with a sticky TRAP.
// Owns PC, instruction register, writeback select and both memory handshakes.
module core_seq
  import core_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  input  instype_t    itype,
  input  logic [31:0] imm,
  input  logic [31:0] rf1,
  input  logic [31:0] rf2,
  input  logic [31:0] alu_result,
  output logic [31:0] pc,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        trap
);
  seqstate_t   state;
  seqstate_t   exec_next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] pc_plus4;
  logic [31:0] pc_imm;
  logic [31:0] npc_raw;
  logic [31:0] next_pc;
  logic [31:0] res_q;
  logic [31:0] link_q;
  logic [31:0] ld_q;
  logic [31:0] npc_q;
  logic        wen_d;
  logic        wen_q;
  wbsel_t      wbsel_d;
  wbsel_t      wbsel_q;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_wdata;
  logic [31:0] lsu_ld;
  logic        unused_rf1;

  assign opcode     = ins[6:0];
  assign funct3     = ins[14:12];
  assign rd         = ins[11:7];
  assign pc_plus4   = pc + 32'd4;
  assign pc_imm     = pc + imm;
  assign unused_rf1 = ^rf1;

  // EXEC decisions, valid while ins/decoder/ALU have settled in S_EXEC.
  always_comb begin
    npc_raw   = pc_plus4;
    wbsel_d   = WB_ALU;
    wen_d     = (rd != 5'd0);
    exec_next = S_WB;
    case (opcode)
      OP_BRANCH: begin
        wen_d = 1'b0;
        if (alu_result[0] ^ ins[12]) npc_raw = pc_imm;
      end
      OP_JAL: begin
        npc_raw = pc_imm;
        wbsel_d = WB_LINK;
      end
      OP_JALR: begin
        npc_raw = {alu_result[31:1], 1'b0};
        wbsel_d = WB_LINK;
      end
      OP_LOAD: begin
        wbsel_d   = WB_MEM;
        exec_next = S_MEM;
      end
      OP_STORE: begin
        wen_d     = 1'b0;
        exec_next = S_MEM;
      end
      OP_OPIMM, OP_OP, OP_LUI, OP_AUIPC: ;
      default: exec_next = S_TRAP;
    endcase
    if (itype == IT_ILL) exec_next = S_TRAP;
    if (TRAP_ON_MISALIGN) begin
      if (npc_raw[1:0] != 2'b00) exec_next = S_TRAP;
      // Catch misaligned data here so S_MEM is never entered and no request is issued.
      if (exec_next == S_MEM && misaligned(funct3, alu_result[1:0])) exec_next = S_TRAP;
      next_pc = npc_raw;
    end else begin
      next_pc = {npc_raw[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ins     <= INS_NOP;
      res_q   <= 32'h0;
      link_q  <= 32'h0;
      ld_q    <= 32'h0;
      npc_q   <= RESET_PC;
      wbsel_q <= WB_ALU;
      wen_q   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            ins   <= imem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res_q   <= alu_result;
          link_q  <= pc_plus4;
          npc_q   <= next_pc;
          wbsel_q <= wbsel_d;
          wen_q   <= wen_d;
          state   <= exec_next;
        end
        S_MEM: begin
          if (dmem_ack) begin
            ld_q  <= lsu_ld;
            state <= S_WB;
          end
        end
        S_WB: begin
          pc    <= npc_q;
          state <= S_FETCH;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

  core_seq_lsu_align u_lsu (
    .funct3  (funct3),
    .addr_lo (res_q[1:0]),
    .st_data (rf2),
    .ld_word (dmem_rdata),
    .be      (lsu_be),
    .wdata   (lsu_wdata),
    .ld_data (lsu_ld)
  );

  // Handshake: req stays high with stable address/data until ack is seen at a
  // rising edge; ack in the same cycle as req completes the access.
  assign imem_req   = (state == S_FETCH) && !rst;
  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM) && !rst;
  assign dmem_we    = (state == S_MEM) && (opcode == OP_STORE);
  assign dmem_addr  = {res_q[31:2], 2'b00};
  assign dmem_be    = (state == S_MEM) ? lsu_be : 4'b0000;
  assign dmem_wdata = lsu_wdata;
  assign rf_we      = (state == S_WB) && wen_q;
  assign trap       = (state == S_TRAP);

  always_comb begin
    case (wbsel_q)
      WB_MEM:  rf_wdata = ld_q;
      WB_LINK: rf_wdata = link_q;
      default: rf_wdata = res_q;
    endcase
  end

endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: directed table, randomized instruction stream against a
// behavioural model, and hand-written reset/trap sequences.
module tb_core_seq;
  import core_seq_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata, ins;
  instype_t    itype;
  logic [31:0] imm, rf1, rf2, alu_result, pc;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        rf_we, trap;
  logic [31:0] rf_wdata;

  core_seq #(.RESET_PC(RPC), .TRAP_ON_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ins(ins), .itype(itype), .imm(imm), .rf1(rf1), .rf2(rf2), .alu_result(alu_result),
    .pc(pc), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .trap(trap)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins, imm, alu, rf2, rdata;
    int          ilat, dlat;
    bit          hand;
    logic [31:0] enpc, ewd;
  } vec_t;

  typedef struct {
    logic [31:0] npc, wdata, addr, wd;
    logic [3:0]  be;
    bit          wen, mem, we, trap;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (pc model %h)", name, act, exp, m_pc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, input logic [31:0] im, input logic [31:0] a,
                              input logic [31:0] r2, input logic [31:0] rd, input int il,
                              input int dl, input logic [31:0] enpc, input logic [31:0] ewd);
    vec_t v;
    v.ins = i; v.imm = im; v.alu = a; v.rf2 = r2; v.rdata = rd;
    v.ilat = il; v.dlat = dl; v.hand = 1'b1; v.enpc = enpc; v.ewd = ewd;
    return v;
  endfunction

  // Stand-in decoder: format from the opcode, unknown opcodes rejected.
  function automatic instype_t decode_type(input logic [31:0] w);
    case (w[6:0])
      7'h33:                      return IT_R;
      7'h13, 7'h03, 7'h67, 7'h73: return IT_I;
      7'h23:                      return IT_S;
      7'h63:                      return IT_B;
      7'h37, 7'h17:               return IT_U;
      7'h6F:                      return IT_J;
      default:                    return IT_ILL;
    endcase
  endfunction

  // Reference model: what one instruction at pc must do, from the ISA rules.
  function automatic exp_t model(input vec_t v, input logic [31:0] cur_pc);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    int          size, off;
    logic [31:0] raw, mask;
    opc = v.ins[6:0];
    f3  = v.ins[14:12];
    e = '{default: 0};
    e.npc   = cur_pc + 32'd4;
    e.wdata = v.alu;
    e.wen   = (v.ins[11:7] != 5'd0);
    e.cyc   = 3 + v.ilat;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(v.alu[1:0]);
    case (opc)
      7'h63: begin
        e.wen = 1'b0;
        if (v.alu[0] != f3[0]) e.npc = cur_pc + v.imm;
      end
      7'h6F: begin e.npc = cur_pc + v.imm; e.wdata = cur_pc + 32'd4; end
      7'h67: begin e.npc = v.alu & ~32'd1; e.wdata = cur_pc + 32'd4; end
      7'h03, 7'h23: begin
        if (off % size != 0) e.trap = 1'b1;
        else begin
          e.mem  = 1'b1;
          e.we   = (opc == 7'h23);
          e.addr = v.alu & ~32'd3;
          e.be   = 4'(((1 << size) - 1) << off);
          e.cyc  = 4 + v.ilat + v.dlat;
          if (e.we) begin
            e.wen = 1'b0;
            e.wd  = (size == 1) ? v.rf2[7:0] * 32'h0101_0101 :
                    (size == 2) ? v.rf2[15:0] * 32'h0001_0001 : v.rf2;
          end else begin
            raw  = v.rdata >> (8 * off);
            mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
            e.wdata = raw & mask;
            if (!f3[2] && size < 4 && raw[8*size-1]) e.wdata = e.wdata | ~mask;
          end
        end
      end
      7'h13, 7'h33, 7'h37, 7'h17: ;
      default: e.trap = 1'b1;
    endcase
    if (e.npc[1:0] != 2'b00) e.trap = 1'b1;
    if (e.trap) begin e.wen = 1'b0; e.mem = 1'b0; e.cyc = 2 + v.ilat; end
    return e;
  endfunction

  // ---- driver tasks (all enter and leave on a negedge) ----
  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_pc", pc, RPC);
    check("rst_ins", ins, 32'h0000_0013);
    check("rst_trap", trap, 0);
    check("rst_rf_we", rf_we, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_dmem_be", dmem_be, 0);
    rst = 1'b0;
    m_pc = RPC;
    exp_q.delete();
  endtask

  task automatic do_fetch(input vec_t v, output bit ok);
    int n;
    bit moved;
    itype = decode_type(v.ins); imm = v.imm; alu_result = v.alu;
    rf2 = v.rf2; rf1 = $urandom; dmem_rdata = v.rdata;
    n = 0;
    while (!imem_req && n < 20) begin @(negedge clk); n++; end
    ok = imem_req;
    check("fetch_req", imem_req, 1);
    if (!ok) return;
    check("fetch_addr", imem_addr, m_pc);
    moved = 1'b0;
    for (int i = 0; i < v.ilat; i++) begin
      @(negedge clk);
      if (!imem_req || imem_addr !== m_pc) moved = 1'b1;
    end
    if (v.ilat > 0) check("fetch_stable", moved, 0);
    imem_rdata = v.ins; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
  endtask

  task automatic run_instr(input vec_t v);
    exp_t e;
    bit   ok, mem_bad, hold_bad;
    int   n, mcyc, wcnt;
    e = model(v, m_pc);
    if (v.hand) begin e.npc = v.enpc; e.wdata = v.ewd; end
    if (e.wen) exp_q.push_back(e.wdata);
    do_fetch(v, ok);
    if (!ok) return;
    n = 1 + v.ilat; mcyc = 0; wcnt = 0; mem_bad = 1'b0;
    while (n < 40) begin
      dmem_ack = 1'b0;
      if (imem_req || trap) break;
      n++;
      if (dmem_req) begin
        mcyc++;
        if (dmem_we !== e.we || dmem_addr !== e.addr || dmem_be !== e.be) mem_bad = 1'b1;
        if (e.we && dmem_wdata !== e.wd) mem_bad = 1'b1;
        if (mcyc > v.dlat) dmem_ack = 1'b1;
      end
      if (rf_we) begin
        wcnt++;
        if (exp_q.size() > 0) check("rf_wdata", rf_wdata, exp_q.pop_front());
      end
      @(negedge clk);
    end
    dmem_ack = 1'b0;
    check("cycles", n, e.cyc);
    check("trap", trap, e.trap);
    check("rf_we_pulses", wcnt, e.wen);
    check("mem_cycles", mcyc, e.mem ? v.dlat + 1 : 0);
    if (e.mem) check("mem_fields", mem_bad, 0);
    exp_q.delete();
    if (e.trap) begin
      hold_bad = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (!trap || imem_req || dmem_req || rf_we || pc !== m_pc) hold_bad = 1'b1;
      end
      check("trap_hold", hold_bad, 0);
    end else begin
      m_pc = e.npc;
    end
  endtask

  // ---- stimulus and scoreboard ----
  initial begin
    vec_t        tbl[$];
    vec_t        traps[$];
    vec_t        r;
    bit          ok, bad;
    int          n, k, d;
    logic [4:0]  rdx;
    logic [2:0]  f3;
    logic [31:0] a;

    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'h0;
    itype = IT_I; imm = 32'h0; rf1 = 32'h0; rf2 = 32'h0; alu_result = 32'h0; dmem_rdata = 32'h0;

    //            ins           imm           alu           rf2           rdata        il dl  enpc          ewd
    tbl.push_back(mk(32'h0050_0093, 32'd5,        32'd5,        32'h0,        32'h0,        0, 0, 32'h0000_0104, 32'd5));
    tbl.push_back(mk(32'h0000_006F, 32'h0000_00FC, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0000_0200, 32'h0));
    tbl.push_back(mk(32'h0000_0063, 32'hFFFF_FFF8, 32'd1,       32'h0,        32'h0,        0, 0, 32'h0000_01F8, 32'h0));
    tbl.push_back(mk(32'h0000_006F, 32'd8,        32'h0,        32'h0,        32'h0,        1, 0, 32'h0000_0200, 32'h0));
    tbl.push_back(mk(32'h0000_1063, 32'hFFFF_FFF8, 32'd1,       32'h0,        32'h0,        0, 0, 32'h0000_0204, 32'h0));
    tbl.push_back(mk(32'h0000_0023, 32'h3,        32'h0000_1003, 32'h0000_00AB, 32'h0,      0, 0, 32'h0000_0208, 32'h0));
    tbl.push_back(mk(32'h0000_0283, 32'h3,        32'h0000_1003, 32'h0,       32'h8000_0000, 0, 0, 32'h0000_020C, 32'hFFFF_FF80));
    tbl.push_back(mk(32'h0000_5303, 32'h2,        32'h0000_1002, 32'h0,       32'h8001_2345, 1, 0, 32'h0000_0210, 32'h0000_8001));
    tbl.push_back(mk(32'h0000_1303, 32'h0,        32'h0000_1000, 32'h0,       32'h1234_F00D, 0, 1, 32'h0000_0214, 32'hFFFF_F00D));
    tbl.push_back(mk(32'h0000_2383, 32'h0,        32'h0000_2000, 32'h0,       32'hDEAD_BEEF, 0, 5, 32'h0000_0218, 32'hDEAD_BEEF));
    tbl.push_back(mk(32'h0000_1023, 32'h2,        32'h0000_1002, 32'h1234_5678, 32'h0,      0, 2, 32'h0000_021C, 32'h0));
    tbl.push_back(mk(32'h0000_2023, 32'h0,        32'h0000_3000, 32'hCAFE_F00D, 32'h0,      0, 0, 32'h0000_0220, 32'h0));
    tbl.push_back(mk(32'h0000_4203, 32'h1,        32'h0000_1001, 32'h0,       32'h0000_9A00, 0, 0, 32'h0000_0224, 32'h0000_009A));
    tbl.push_back(mk(32'h1234_5437, 32'h1234_5000, 32'h1234_5000, 32'h0,      32'h0,        0, 0, 32'h0000_0228, 32'h1234_5000));
    tbl.push_back(mk(32'h0000_0497, 32'h0000_1000, 32'h0000_1234, 32'h0,      32'h0,        0, 0, 32'h0000_022C, 32'h0000_1234));
    tbl.push_back(mk(32'h0000_5063, 32'h0000_0040, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0000_026C, 32'h0));
    tbl.push_back(mk(32'h0000_00EF, 32'h0000_0010, 32'h0,       32'h0,        32'h0,        0, 0, 32'h0000_027C, 32'h0000_0270));
    tbl.push_back(mk(32'h0000_0067, 32'h0,        32'hFFFF_FFFD, 32'h0,       32'h0,        0, 0, 32'hFFFF_FFFC, 32'h0));
    tbl.push_back(mk(32'h0000_0113, 32'd7,        32'd7,        32'h0,        32'h0,        0, 0, 32'h0000_0000, 32'd7));
    tbl.push_back(mk(32'h0000_00E7, 32'h0,        32'h0000_0101, 32'h0,       32'h0,        0, 0, 32'h0000_0100, 32'h0000_0004));
    tbl.push_back(mk(32'h0000_0533, 32'h0,        32'h0000_55AA, 32'h0,       32'h0,        0, 0, 32'h0000_0104, 32'h0000_55AA));
    tbl.push_back(mk(32'h0990_0013, 32'h99,       32'h99,       32'h0,        32'h0,        0, 0, 32'h0000_0108, 32'h0));

    // Each of these must trap; a reset precedes every one.
    traps.push_back(mk(32'h0000_0073, 32'h0, 32'h0,         32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    traps.push_back(mk(32'h0000_00E7, 32'h0, 32'h0000_0203, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    traps.push_back(mk(32'h0000_2383, 32'h0, 32'h0000_1001, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    traps.push_back(mk(32'h0000_1023, 32'h0, 32'h0000_1001, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    traps.push_back(mk(32'h0000_000F, 32'h0, 32'h0,         32'h0, 32'h0, 0, 0, 32'h0, 32'h0));
    traps.push_back(mk(32'h0000_007F, 32'h0, 32'h0,         32'h0, 32'h0, 1, 0, 32'h0, 32'h0));

    do_reset();
    foreach (tbl[i]) run_instr(tbl[i]);

    // Randomized stream of non-trapping instructions.
    for (int i = 0; i < 40; i++) begin
      k   = $urandom_range(0, 5);
      rdx = 5'($urandom_range(0, 31));
      a   = $urandom;
      r   = mk(32'h0, 32'h0, a, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 32'h0, 32'h0);
      r.hand = 1'b0;
      case (k)
        0: r.ins = {12'h0, 5'd0, 3'd0, rdx, 7'h13};
        1: r.ins = {7'h0, 10'h0, 3'd0, rdx, 7'h33};
        2: begin
          d = $urandom_range(0, 5);
          f3 = (d < 2) ? 3'(d) : 3'(d + 2);
          r.ins = {17'h0, f3, 5'h0, 7'h63};
          r.alu = 32'($urandom_range(0, 1));
          d = $urandom_range(0, 64);
          r.imm = 32'((d - 32) * 4);
        end
        3: begin
          d = $urandom_range(0, 4);
          f3 = (d < 3) ? 3'(d) : 3'(d + 1);
          if (f3[1:0] == 2'b01) a[0] = 1'b0;
          if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
          r.alu = a;
          r.ins = {17'h0, f3, rdx, 7'h03};
        end
        4: begin
          f3 = 3'($urandom_range(0, 2));
          if (f3[1:0] == 2'b01) a[0] = 1'b0;
          if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
          r.alu = a;
          r.ins = {17'h0, f3, 5'h0, 7'h23};
        end
        default: begin
          d = $urandom_range(0, 64);
          r.imm = 32'((d - 32) * 4);
          r.ins = {20'h0, rdx, 7'h6F};
        end
      endcase
      run_instr(r);
    end

    // Reset while a store is waiting in S_MEM, then a late ack.
    r = mk(32'h0000_2023, 32'h0, 32'h0000_4000, 32'h1111_2222, 32'h0, 0, 0, 32'h0, 32'h0);
    do_fetch(r, ok);
    n = 0;
    while (!dmem_req && n < 5) begin @(negedge clk); n++; end
    check("midmem_req_seen", dmem_req, 1);
    rst = 1'b1;
    #1;
    check("midmem_req_drop", dmem_req, 0);
    check("midmem_imem_req_rst", imem_req, 0);
    @(negedge clk);
    rst = 1'b0; dmem_ack = 1'b1;
    check("midmem_pc", pc, RPC);
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rf_we || dmem_req || !imem_req || imem_addr !== RPC) bad = 1'b1;
    end
    dmem_ack = 1'b0;
    check("late_ack_ignored", bad, 0);
    m_pc = RPC;
    exp_q.delete();
    run_instr(mk(32'h0050_0093, 32'd5, 32'd5, 32'h0, 32'h0, 0, 0, 32'h0000_0104, 32'd5));

    foreach (traps[i]) begin
      do_reset();
      run_instr(traps[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
